// File: rtl/fifo_axis_drain_if.sv
// fifo_axis_drain_if: AXI-Stream beat bundle between the drain controller and its consumer
interface fifo_axis_drain_if #(
    parameter int WIDTH = 64
);
    logic [WIDTH-1:0] m_data;
    logic             m_valid;
    logic             m_last;
    logic             m_ready;
    modport master (output m_data, m_valid, m_last, input m_ready);
    modport slave  (input m_data, m_valid, m_last, output m_ready);
endinterface

// File: rtl/fifo_axis_drain.sv
// fifo_axis_drain: pops the upstream FIFO and replays its words as a framed AXI-Stream
module fifo_axis_drain #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 1024,
    parameter int BEATS = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   fifo_push_ok,
    input  logic                   fifo_empty,
    input  logic [WIDTH-1:0]       fifo_data,
    output logic                   fifo_pop,
    output logic [$clog2(DEPTH):0] level,
    fifo_axis_drain_if.master      m
);
    localparam int LW = $clog2(DEPTH) + 1;
    localparam int BW = BEATS > 1 ? $clog2(BEATS) : 1;
    logic [LW-1:0]    level_q, level_d;
    logic             pop_d1_q, pop_d1_d;
    logic [1:0]       buf_cnt_q, buf_cnt_d, held;
    logic [WIDTH-1:0] head_q, head_d, tail_q, tail_d;
    logic [BW-1:0]    beat_q, beat_d;
    logic             fire;
    // Pop gating sees the retire of this cycle so a full buffer still streams one beat per cycle
    always_comb begin
        m.m_valid = buf_cnt_q != 2'd0;
        m.m_data  = head_q;
        m.m_last  = m.m_valid & (beat_q == BW'(BEATS - 1));
        level     = level_q;
        fire      = m.m_valid & m.m_ready;
        fifo_pop  = (level_q != '0) & ~fifo_empty &
                    (({1'b0, buf_cnt_q} + {2'b0, pop_d1_q} - {2'b0, fire}) < 3'd2);
        pop_d1_d  = fifo_pop;
        held      = buf_cnt_q - {1'b0, fire};
        head_d    = (pop_d1_q && held == 2'd0) ? fifo_data : fire ? tail_q : head_q;
        tail_d    = (pop_d1_q && held != 2'd0) ? fifo_data : tail_q;
        buf_cnt_d = held + {1'b0, pop_d1_q};
        level_d   = (fifo_push_ok & ~fifo_pop & (level_q != LW'(DEPTH))) ? level_q + 1'b1 :
                    (~fifo_push_ok & fifo_pop) ? level_q - 1'b1 : level_q;
        beat_d    = fire ? ((beat_q == BW'(BEATS - 1)) ? '0 : beat_q + 1'b1) : beat_q;
    end
    // State registers; reset also drops any capture still in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            level_q   <= '0;
            pop_d1_q  <= 1'b0;
            buf_cnt_q <= '0;
            head_q    <= '0;
            tail_q    <= '0;
            beat_q    <= '0;
        end else begin
            level_q   <= level_d;
            pop_d1_q  <= pop_d1_d;
            buf_cnt_q <= buf_cnt_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            beat_q    <= beat_d;
        end
    end
endmodule

// File: tb/tb_fifo_axis_drain.sv
// tb_fifo_axis_drain: lagging-empty FIFO model plus scoreboard around the drain controller
module tb_fifo_axis_drain;
    localparam int WIDTH = 64;
    localparam int DEPTH = 32;
    localparam int BEATS = 16;

    typedef struct {
        int n;
        bit hold;
        int hold_pops;
        int span;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic fifo_push_ok = 1'b0;
    logic fifo_empty = 1'b1;
    logic fifo_pop;
    logic [WIDTH-1:0] fifo_data = '0;
    logic [WIDTH-1:0] push_data = '0;
    logic [$clog2(DEPTH):0] level;

    fifo_axis_drain_if #(.WIDTH(WIDTH)) axis ();

    fifo_axis_drain #(.WIDTH(WIDTH), .DEPTH(DEPTH), .BEATS(BEATS)) dut (
        .clk(clk),
        .reset(reset),
        .fifo_push_ok(fifo_push_ok),
        .fifo_empty(fifo_empty),
        .fifo_data(fifo_data),
        .fifo_pop(fifo_pop),
        .level(level),
        .m(axis)
    );

    // Free-running clock
    always #5 clk = ~clk;

    int checks = 0, fails = 0, cyc = 0, pops = 0, fires = 0;
    int first_fire = -1, last_fire = -1, sb_beat = 0;
    logic [WIDTH-1:0] fq[$];
    logic [WIDTH-1:0] exp_q[$];
    logic pop_s, push_s, rst_s;
    logic prev_v = 1'b0, prev_r = 1'b0, prev_l = 1'b0;
    logic [WIDTH-1:0] prev_d = '0, dat_s = '0;

    task automatic chk(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic mon();
        logic [WIDTH-1:0] e;
        if (reset) begin
            prev_v = 1'b0;
            return;
        end
        chk("level_track", level, fq.size());
        chk("pop_guard", fifo_pop && level == 0, 0);
        if (prev_v && !prev_r) begin
            chk("stall_valid", axis.m_valid, 1);
            chk("stall_data", axis.m_data, prev_d);
            chk("stall_last", axis.m_last, prev_l);
        end
        if (axis.m_valid && axis.m_ready) begin
            chk("beat_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("beat_data", axis.m_data, e);
            end
            chk("beat_last", axis.m_last, sb_beat == BEATS - 1);
            sb_beat = (sb_beat == BEATS - 1) ? 0 : sb_beat + 1;
            fires++;
            if (first_fire < 0) first_fire = cyc;
            last_fire = cyc;
        end
        pops += int'(fifo_pop);
        prev_v = axis.m_valid;
        prev_r = axis.m_ready;
        prev_d = axis.m_data;
        prev_l = axis.m_last;
    endtask

    task automatic step();
        int old;
        @(negedge clk);
        mon();
        pop_s  = fifo_pop;
        push_s = fifo_push_ok;
        dat_s  = push_data;
        rst_s  = reset;
        @(posedge clk);
        #1;
        cyc++;
        if (rst_s) begin
            fq.delete();
            exp_q.delete();
            sb_beat    = 0;
            fifo_empty = 1'b1;
            fifo_data  = '0;
        end else begin
            old = fq.size();
            if (push_s) fq.push_back(dat_s);
            if (pop_s) begin
                chk("pop_underflow", old != 0, 1);
                if (fq.size() != 0) fifo_data = fq.pop_front();
            end
            fifo_empty = (old == 0);
        end
    endtask

    task automatic push_word();
        push_data = {$urandom, $urandom};
        fifo_push_ok = 1'b1;
        exp_q.push_back(push_data);
    endtask

    task automatic drain(input string name);
        int k = 0;
        axis.m_ready = 1'b1;
        while ((exp_q.size() != 0 || level != 0) && k < 300) begin
            step();
            k++;
        end
        chk(name, k < 300, 1);
        repeat (3) step();
    endtask

    task automatic chk_rst();
        #1;
        chk("rst_pop", fifo_pop, 0);
        chk("rst_valid", axis.m_valid, 0);
        chk("rst_last", axis.m_last, 0);
        chk("rst_data", axis.m_data, 0);
        chk("rst_level", level, 0);
    endtask

    // Stimulus, table vectors and hand-written corner sequences
    initial begin
        vec_t vecs[3];
        int p0, f0, sent;
        bit found;
        logic [WIDTH-1:0] hd;
        vecs[0] = '{5, 1'b0, 0, 4};
        vecs[1] = '{32, 1'b0, 0, 31};
        vecs[2] = '{8, 1'b1, 2, 7};
        axis.m_ready = 1'b0;
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        chk_rst();
        for (int v = 0; v < 3; v++) begin
            p0 = pops;
            f0 = fires;
            first_fire = -1;
            axis.m_ready = !vecs[v].hold;
            hd = '0;
            for (int i = 0; i < vecs[v].n; i++) begin
                push_word();
                if (i == 0) hd = push_data;
                step();
            end
            fifo_push_ok = 1'b0;
            if (vecs[v].hold) begin
                repeat (10) step();
                chk("hold_pops", pops - p0, vecs[v].hold_pops);
                #1;
                chk("hold_valid", axis.m_valid, 1);
                chk("hold_head", axis.m_data, hd);
            end
            drain("vec_drain");
            chk("vec_pops", pops - p0, vecs[v].n);
            chk("vec_beats", fires - f0, vecs[v].n);
            chk("vec_span", last_fire - first_fire, vecs[v].span);
        end
        axis.m_ready = 1'b1;
        p0 = pops;
        f0 = fires;
        push_word();
        step();
        fifo_push_ok = 1'b0;
        step();
        chk("lag_no_pop", pops - p0, 0);
        step();
        chk("lag_pop", pops - p0, 1);
        step();
        chk("drained_no_pop", pops - p0, 1);
        drain("lag_drain");
        chk("lag_beats", fires - f0, 1);
        p0 = pops;
        f0 = fires;
        sent = 0;
        while (sent < 1000) begin
            if ($urandom_range(0, 1) == 1 && fq.size() < DEPTH) begin
                push_word();
                sent++;
            end else begin
                fifo_push_ok = 1'b0;
            end
            axis.m_ready = $urandom_range(0, 1) == 1;
            step();
        end
        fifo_push_ok = 1'b0;
        drain("rand_drain");
        chk("rand_pops", pops - p0, 1000);
        chk("rand_beats", fires - f0, 1000);
        reset = 1'b1;
        step();
        reset = 1'b0;
        axis.m_ready = 1'b1;
        found = 1'b0;
        for (int k = 0; k < 40 && !found; k++) begin
            if (k < 24) push_word();
            else fifo_push_ok = 1'b0;
            step();
            found = (sb_beat == 7) && pop_s;
        end
        fifo_push_ok = 1'b0;
        chk("rst_setup", found, 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk_rst();
        f0 = fires;
        for (int i = 0; i < 16; i++) begin
            push_word();
            step();
        end
        fifo_push_ok = 1'b0;
        drain("post_rst_drain");
        chk("post_rst_beats", fires - f0, 16);
        chk("post_rst_beat_wrap", sb_beat, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    // Hard stop in case the run ever wedges
    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
